dmac_bus_arbiter: RTL

// Two-master AHB-Lite arbiter and address/data multiplexer placed directly upstream of
// the DMAC master port. It grants the shared system bus either to the CPU or to the

---
 rtl/dmac_bus_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dmac_bus_arbiter.sv
// Two-master AHB-Lite arbiter and slave-side mux: CPU is parked, DMAC has priority.
// Define ARB_FAIRNESS_EN to bound DMA tenure while the CPU is waiting.
module dmac_bus_arbiter #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned MAX_DMA_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_haddr,
    input  logic [1:0]    cpu_htrans,
    input  logic          cpu_hwrite,
    input  logic [DW-1:0] cpu_hwdata,
    input  logic          Bus_Req,
    input  logic [AW-1:0] MAddress,
    input  logic [1:0]    MTrans,
    input  logic          MWrite,
    input  logic [DW-1:0] MWData,
    input  logic          HReady,
    output logic          cpu_grant,
    output logic          Bus_Grant,
    output logic [AW-1:0] HAddr,
    output logic [1:0]    HTrans,
    output logic          HWrite,
    output logic [DW-1:0] HWData,
    output logic          HMaster
);

    localparam logic [1:0] HTRANS_SEQ = 2'b11;

    typedef enum logic [1:0] {
        PARK = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } state_e;

    state_e     state_q;
    state_e     next_state_c;
    logic [1:0] owner_htrans_c;
    logic       switch_c;
    logic       limit_hit_c;
    logic       dma_blocked_c;

    // Ownership may only move between transfers, never inside a burst.
    assign owner_htrans_c = Bus_Grant ? MTrans : cpu_htrans;
    assign switch_c       = HReady && (owner_htrans_c != HTRANS_SEQ);

    // Address phase follows the registered grant; write data follows the data-phase owner.
    assign HAddr  = Bus_Grant ? MAddress : cpu_haddr;
    assign HTrans = owner_htrans_c;
    assign HWrite = Bus_Grant ? MWrite : cpu_hwrite;
    assign HWData = HMaster ? MWData : cpu_hwdata;

`ifdef ARB_FAIRNESS_EN
    localparam int unsigned CW = $clog2(MAX_DMA_CYCLES + 1);

    logic [CW-1:0] tenure_q;
    logic          cpu_hold_q;

    // Limit is hit on the edge that completes the last allowed DMA cycle.
    assign limit_hit_c   = cpu_req && (32'(tenure_q) >= 32'(MAX_DMA_CYCLES - 1));
    assign dma_blocked_c = cpu_hold_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tenure_q   <= '0;
            cpu_hold_q <= 1'b0;
        end else begin
            if ((state_q != DMA) || (next_state_c != DMA)) begin
                tenure_q <= '0;
            end else if (cpu_req && (tenure_q != CW'(MAX_DMA_CYCLES))) begin
                tenure_q <= tenure_q + CW'(1);
            end

            // A forced handover guarantees the CPU one full switch point.
            if ((state_q == DMA) && (next_state_c == CPU) && limit_hit_c) begin
                cpu_hold_q <= 1'b1;
            end else if ((state_q == CPU) && switch_c) begin
                cpu_hold_q <= 1'b0;
            end
        end
    end
`else
    logic unused_cfg;

    assign limit_hit_c   = 1'b0;
    assign dma_blocked_c = 1'b0;
    assign unused_cfg    = ^MAX_DMA_CYCLES;
`endif

    // Next owner, evaluated only at a switch point.
    always_comb begin
        next_state_c = state_q;
        if (switch_c) begin
            unique case (state_q)
                PARK: begin
                    if (Bus_Req) begin
                        next_state_c = DMA;
                    end else if (cpu_req) begin
                        next_state_c = CPU;
                    end
                end
                CPU: begin
                    if (Bus_Req && !dma_blocked_c) begin
                        next_state_c = DMA;
                    end else if (!cpu_req && !Bus_Req) begin
                        next_state_c = PARK;
                    end
                end
                DMA: begin
                    if (limit_hit_c) begin
                        next_state_c = CPU;
                    end else if (!Bus_Req) begin
                        next_state_c = cpu_req ? CPU : PARK;
                    end
                end
                default: next_state_c = PARK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= PARK;
            cpu_grant <= 1'b1;
            Bus_Grant <= 1'b0;
            HMaster   <= 1'b0;
        end else begin
            state_q   <= next_state_c;
            cpu_grant <= (next_state_c != DMA);
            Bus_Grant <= (next_state_c == DMA);
            if (HReady) begin
                HMaster <= Bus_Grant;
            end
        end
    end

endmodule
